// File: rtl/tpiu_pkg.sv
// Shared constants for the TPIU frame builder: sync patterns and frame geometry.
package tpiu_pkg;
    localparam logic [15:0] SYNC_HI         = 16'hFFFF;
    localparam logic [15:0] SYNC_LO         = 16'h7FFF;
    localparam logic [15:0] HALFSYNC        = 16'h7FFF;
    localparam int          WORDS_PER_FRAME = 8;
    localparam int          WCNT_W          = 3;
endpackage

// File: rtl/tpiu_sync_window.sv
// One-word holding window over the trace stream: detects full/half sync on {prev,cur}
// and presents prev for emission. Optional build macro: HALFSYNC_FILTER_EN.
module tpiu_sync_window
    import tpiu_pkg::*;
(
    input  logic        wrClk,
    input  logic        rst,
    input  logic        wdAvail_i,
    input  logic [15:0] wd_i,
    input  logic        synced_i,
    input  logic        clrPrev_i,
    output logic        isFullSync_o,
    output logic        isHalfSync_o,
    output logic        emitValid_o,
    output logic [15:0] emitWd_o
);
`ifdef HALFSYNC_FILTER_EN
    localparam bit DROP_HALF = 1'b1;
`else
    localparam bit DROP_HALF = 1'b0;
`endif

    logic [15:0] prev_q, prev_d;
    logic        prevValid_q, prevValid_d;
    logic        halfDrop;

    assign isFullSync_o = wdAvail_i && prevValid_q && (prev_q == SYNC_HI) && (wd_i == SYNC_LO);
    assign isHalfSync_o = wdAvail_i && (wd_i == HALFSYNC) && !isFullSync_o;
    assign halfDrop     = isHalfSync_o && DROP_HALF;
    assign emitValid_o  = wdAvail_i && prevValid_q && synced_i && !isFullSync_o && !halfDrop;
    assign emitWd_o     = prev_q;

    // A dropped half-sync leaves the held word untouched so it still goes out in order.
    always_comb begin
        prev_d      = prev_q;
        prevValid_d = prevValid_q;
        if (clrPrev_i) begin
            prevValid_d = 1'b0;
        end else if (wdAvail_i) begin
            if (isFullSync_o) begin
                prevValid_d = 1'b0;
            end else if (!halfDrop) begin
                prev_d      = wd_i;
                prevValid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wrClk) begin
        if (rst) begin
            prev_q      <= '0;
            prevValid_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            prevValid_q <= prevValid_d;
        end
    end
endmodule

// File: rtl/tpiu_frame_builder.sv
// TPIU frame builder: strips full-frame sync, groups data into 8-word frames and drives
// the packet buffer handshake. Optional build macro: HALFSYNC_FILTER_EN (in tpiu_sync_window).
module tpiu_frame_builder
    import tpiu_pkg::*;
#(
    parameter int MAX_NOSYNC_FRAMES = 1023,
    parameter int NOSYNC_CNT_W      = 10
) (
    input  logic        wrClk,
    input  logic        rst,
    input  logic        TraceWdAvail,
    input  logic [15:0] TraceWd,
    output logic        WdAvail,
    output logic [15:0] PacketWd,
    output logic        PacketCommit,
    output logic        PacketReset,
    output logic        Synced,
    output logic [7:0]  SyncLossCnt
);
    localparam logic [NOSYNC_CNT_W-1:0] MAX_C  = NOSYNC_CNT_W'(MAX_NOSYNC_FRAMES);
    localparam logic [WCNT_W-1:0]       LAST_W = WCNT_W'(WORDS_PER_FRAME - 1);

    logic                    wdAvail_q, wdAvail_d;
    logic [15:0]             packetWd_q, packetWd_d;
    logic                    commit_q, commit_d;
    logic                    pktReset_q, pktReset_d;
    logic                    synced_q, synced_d;
    logic [7:0]              lossCnt_q, lossCnt_d;
    logic [WCNT_W-1:0]       wordCnt_q, wordCnt_d;
    logic [NOSYNC_CNT_W-1:0] nosync_q, nosync_d, nosyncInc;
    logic                    commitPend_q, commitPend_d;
    logic                    clrPrev;
    logic                    isFullSync, isHalfSync, emitValid;
    logic [15:0]             emitWd;

    tpiu_sync_window u_win (
        .wrClk       (wrClk),
        .rst         (rst),
        .wdAvail_i   (TraceWdAvail),
        .wd_i        (TraceWd),
        .synced_i    (synced_q),
        .clrPrev_i   (clrPrev),
        .isFullSync_o(isFullSync),
        .isHalfSync_o(isHalfSync),
        .emitValid_o (emitValid),
        .emitWd_o    (emitWd)
    );

    assign nosyncInc = (nosync_q == '1) ? nosync_q : nosync_q + 1'b1;

    // Commit lands the cycle after the last word; input spacing guarantees no word arrives then.
    always_comb begin
        wdAvail_d    = 1'b0;
        packetWd_d   = packetWd_q;
        commit_d     = 1'b0;
        pktReset_d   = 1'b0;
        synced_d     = synced_q;
        lossCnt_d    = lossCnt_q;
        wordCnt_d    = wordCnt_q;
        nosync_d     = nosync_q;
        commitPend_d = 1'b0;
        clrPrev      = 1'b0;
        if (isFullSync) begin
            synced_d = 1'b1;
            nosync_d = '0;
            if (wordCnt_q != '0) begin
                pktReset_d = 1'b1;
                wordCnt_d  = '0;
            end
        end else if (emitValid) begin
            wdAvail_d    = 1'b1;
            packetWd_d   = emitWd;
            wordCnt_d    = wordCnt_q + 1'b1;
            commitPend_d = (wordCnt_q == LAST_W);
        end
        if (commitPend_q) begin
            commit_d = 1'b1;
            nosync_d = nosyncInc;
            if ((MAX_NOSYNC_FRAMES != 0) && (nosyncInc >= MAX_C)) begin
                synced_d  = 1'b0;
                clrPrev   = 1'b1;
                lossCnt_d = (lossCnt_q == 8'hFF) ? lossCnt_q : lossCnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge wrClk) begin
        if (rst) begin
            wdAvail_q    <= 1'b0;
            packetWd_q   <= '0;
            commit_q     <= 1'b0;
            pktReset_q   <= 1'b0;
            synced_q     <= 1'b0;
            lossCnt_q    <= '0;
            wordCnt_q    <= '0;
            nosync_q     <= '0;
            commitPend_q <= 1'b0;
        end else begin
            wdAvail_q    <= wdAvail_d;
            packetWd_q   <= packetWd_d;
            commit_q     <= commit_d;
            pktReset_q   <= pktReset_d;
            synced_q     <= synced_d;
            lossCnt_q    <= lossCnt_d;
            wordCnt_q    <= wordCnt_d;
            nosync_q     <= nosync_d;
            commitPend_q <= commitPend_d;
        end
    end

    assign WdAvail      = wdAvail_q;
    assign PacketWd     = packetWd_q;
    assign PacketCommit = commit_q;
    assign PacketReset  = pktReset_q;
    assign Synced       = synced_q;
    assign SyncLossCnt  = lossCnt_q;
endmodule
